// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side handshake bundle for the decode queue
interface decode_queue_if #(
    parameter int OP_W = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [31:0]     in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic [31:0]     out_pc;
    logic            out_is_load;
    logic            out_is_store;
    logic            out_is_branch;
    logic            out_is_jump;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc,
        input  out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc,
        output out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode-at-enqueue FIFO; the output path is pure storage read
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    decode_queue_if.slave          q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_LBU   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SH    = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(18);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [31:0]     pc;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        dec;
    entry_t        head_e;
    logic          ill;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;
    logic [31:0]   inst;
    logic [6:0]    opc;
    logic [2:0]    f3;
    logic          alt;
    logic          f7_bad;
    logic [31:0]   imm_i;
    logic [31:0]   imm_s;
    logic [31:0]   imm_b;
    logic [31:0]   imm_j;
    logic [31:0]   imm_u;
    logic [31:0]   imm_sh;

    assign inst   = q.in_inst;
    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign alt    = inst[30];
    assign f7_bad = |{inst[31], inst[29:25]};
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    // Reset gates in_ready combinationally so the queue refuses input while held in reset
    assign q.in_ready = rst_in && rdy_in && !flush_in && (count != CW'(DEPTH));
    assign q.out_valid = (count != '0);
    assign push = q.in_valid && q.in_ready;
    assign pop  = q.out_valid && q.out_ready && rdy_in && !flush_in;

    assign head_e          = mem[head];
    assign q.out_op        = head_e.op;
    assign q.out_rd        = head_e.rd;
    assign q.out_rs1       = head_e.rs1;
    assign q.out_rs2       = head_e.rs2;
    assign q.out_imm       = head_e.imm;
    assign q.out_pc        = head_e.pc;
    assign q.out_is_load   = head_e.is_load;
    assign q.out_is_store  = head_e.is_store;
    assign q.out_is_branch = head_e.is_branch;
    assign q.out_is_jump   = head_e.is_jump;
    assign q.out_illegal   = head_e.illegal;

    // Decode the fetch-side instruction into a full queue entry
    always_comb begin
        dec     = '0;
        ill     = 1'b0;
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.pc  = q.in_pc;
        case (opc)
            OPC_LUI: begin
                dec.op  = OP_LUI;
                dec.imm = imm_u;
                dec.rs1 = '0;
                dec.rs2 = '0;
            end
            OPC_AUIPC: begin
                dec.op  = OP_AUIPC;
                dec.imm = imm_u;
                dec.rs1 = '0;
                dec.rs2 = '0;
            end
            OPC_JAL: begin
                dec.op      = OP_JAL;
                dec.imm     = imm_j;
                dec.rs1     = '0;
                dec.rs2     = '0;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.op      = OP_JALR;
                dec.imm     = imm_i;
                dec.rs2     = '0;
                dec.is_jump = 1'b1;
                ill         = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm       = imm_b;
                dec.rd        = '0;
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    3'b110:  dec.op = OP_BLTU;
                    3'b111:  dec.op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm     = imm_i;
                dec.rs2     = '0;
                dec.is_load = 1'b1;
                case (f3)
                    3'b000:  dec.op = OP_LB;
                    3'b001:  dec.op = OP_LH;
                    3'b010:  dec.op = OP_LW;
                    3'b100:  dec.op = OP_LBU;
                    3'b101:  dec.op = OP_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.imm      = imm_s;
                dec.rd       = '0;
                dec.is_store = 1'b1;
                case (f3)
                    3'b000:  dec.op = OP_SB;
                    3'b001:  dec.op = OP_SH;
                    3'b010:  dec.op = OP_SW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.imm = imm_i;
                dec.rs2 = '0;
                case (f3)
                    3'b000: dec.op = OP_ADDI;
                    3'b010: dec.op = OP_SLTI;
                    3'b011: dec.op = OP_SLTIU;
                    3'b100: dec.op = OP_XORI;
                    3'b110: dec.op = OP_ORI;
                    3'b111: dec.op = OP_ANDI;
                    3'b001: begin
                        dec.op  = OP_SLLI;
                        dec.imm = imm_sh;
                        ill     = f7_bad;
                    end
                    default: begin
                        dec.op  = alt ? OP_SRAI : OP_SRLI;
                        dec.imm = imm_sh;
                        ill     = f7_bad;
                    end
                endcase
            end
            OPC_OP: begin
                ill = f7_bad;
                case (f3)
                    3'b000:  dec.op = alt ? OP_SUB : OP_ADD;
                    3'b001:  dec.op = OP_SLL;
                    3'b010:  dec.op = OP_SLT;
                    3'b011:  dec.op = OP_SLTU;
                    3'b100:  dec.op = OP_XOR;
                    3'b101:  dec.op = alt ? OP_SRA : OP_SRL;
                    3'b110:  dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.op        = '0;
            dec.rd        = '0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    // Entry storage is write-only on push and deliberately left unreset
    always_ff @(posedge clk_in) begin
        if (push)
            mem[tail] <= dec;
    end

    // Pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                if (pop)
                    head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table-driven decode checks plus directed FIFO corner sequences
module tb_decode_queue;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic       flush;
    logic [2:0] count;
    int         n_chk = 0;
    int         n_fail = 0;

    decode_queue_if #(.OP_W(6)) bus ();

    decode_queue #(.DEPTH(4), .OP_W(6)) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .rdy_in(rdy),
        .flush_in(flush),
        .q(bus),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  flg;
        logic        full;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] mq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'hFFF00093;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        // flags: {load, store, branch, jump, illegal}
        vecs[0]  = '{32'hFFF00093, 6'd19, 5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 5'b00000, 1'b1};
        vecs[1]  = '{32'h4041D113, 6'd27, 5'd2,  5'd3, 5'd0, 32'h00000004, 5'b00000, 1'b1};
        vecs[2]  = '{32'hFFDFF06F, 6'd3,  5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 5'b00010, 1'b1};
        vecs[3]  = '{32'h0000707F, 6'd0,  5'd0,  5'd0, 5'd0, 32'h00000000, 5'b00001, 1'b0};
        vecs[4]  = '{32'h00812283, 6'd13, 5'd5,  5'd2, 5'd0, 32'h00000008, 5'b10000, 1'b1};
        vecs[5]  = '{32'hFE63AE23, 6'd18, 5'd0,  5'd7, 5'd6, 32'hFFFFFFFC, 5'b01000, 1'b1};
        vecs[6]  = '{32'hFE208CE3, 6'd5,  5'd0,  5'd1, 5'd2, 32'hFFFFFFF8, 5'b00100, 1'b1};
        vecs[7]  = '{32'h405201B3, 6'd29, 5'd3,  5'd4, 5'd5, 32'h00000000, 5'b00000, 1'b1};
        vecs[8]  = '{32'h12345537, 6'd1,  5'd10, 5'd0, 5'd0, 32'h12345000, 5'b00000, 1'b1};
        vecs[9]  = '{32'h004300E7, 6'd4,  5'd1,  5'd6, 5'd0, 32'h00000004, 5'b00010, 1'b1};
        vecs[10] = '{32'h021080B3, 6'd0,  5'd0,  5'd0, 5'd0, 32'h00000000, 5'b00001, 1'b0};
        vecs[11] = '{32'h0000B003, 6'd0,  5'd0,  5'd0, 5'd0, 32'h00000000, 5'b00001, 1'b0};
        vecs[12] = '{32'h009433B3, 6'd32, 5'd7,  5'd8, 5'd9, 32'h00000000, 5'b00000, 1'b1};
        vecs[13] = '{32'h01F11093, 6'd25, 5'd1,  5'd2, 5'd0, 32'h0000001F, 5'b00000, 1'b1};

        rst_n = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = vecs[i].inst;
            bus.in_pc    = 32'h1000 + 32'(i * 4);
            step();
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_op", i), 32'(bus.out_op), 32'(vecs[i].op));
            check($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_flags", i), 32'({bus.out_is_load, bus.out_is_store, bus.out_is_branch, bus.out_is_jump, bus.out_illegal}), 32'(vecs[i].flg));
            check($sformatf("v%0d_pc", i), bus.out_pc, 32'h1000 + 32'(i * 4));
            if (vecs[i].full) begin
                check($sformatf("v%0d_rs1", i), 32'(bus.out_rs1), 32'(vecs[i].rs1));
                check($sformatf("v%0d_rs2", i), 32'(bus.out_rs2), 32'(vecs[i].rs2));
                check($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check($sformatf("v%0d_drained", i), 32'(count), 32'd0);
        end

        // Fill past capacity with out_ready low, then drain in order
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'hFFF00093;
            bus.in_pc    = 32'h100 + 32'(k * 4);
            #1;
            check($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
            check($sformatf("fill%0d_count", k), 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("drain%0d_pc", k), bus.out_pc, 32'h100 + 32'(k * 4));
            step();
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Steady push+pop at occupancy 2 across pointer wrap
        mq.delete();
        push_one(32'h200);
        mq.push_back(32'h200);
        push_one(32'h204);
        mq.push_back(32'h204);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_pc = 32'h208 + 32'(k * 4);
            #1;
            check($sformatf("pp%0d_head_pc", k), bus.out_pc, mq[0]);
            step();
            mq.push_back(32'h208 + 32'(k * 4));
            void'(mq.pop_front());
            check($sformatf("pp%0d_count", k), 32'(count), 32'd2);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("pp_tail%0d_pc", k), bus.out_pc, mq[0]);
            void'(mq.pop_front());
            step();
        end
        check("pp_end_count", 32'(count), 32'd0);
        bus.out_ready = 1'b0;

        // Flush at occupancy 3 with a competing push and pop
        push_one(32'h300);
        push_one(32'h304);
        push_one(32'h308);
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h3F0;
        bus.out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        push_one(32'h400);
        check("post_flush_count", 32'(count), 32'd1);
        check("post_flush_pc", bus.out_pc, 32'h400);

        // rdy low freezes everything while out_valid still reflects occupancy
        rdy = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h500;
        bus.out_ready = 1'b1;
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        check("stall_count", 32'(count), 32'd1);
        check("stall_pc", bus.out_pc, 32'h400);
        rdy = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("unstall_count", 32'(count), 32'd0);
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of traffic
        push_one(32'h600);
        push_one(32'h604);
        check("pre_arst_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("arst_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_release_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
